// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage widths, NOP word, FSM encoding and helpers
package fetch_stage_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 32;

  // All-zero word decodes as a no-op; used for reset and squashed slots.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // BUBBLE: IF/ID holds a squashed/empty slot. RUN: IF/ID holds a real instruction.
  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_RUN    = 1'b1
  } fetch_state_t;

  // Saturating 16-bit increment for the performance counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-stage bus bundle (next-PC mux, imem, IF/ID); counters under FETCH_PERF_EN
interface fetch_stage_if #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 32
);

  logic [ADDR_W-1:0]  pc_next;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [ADDR_W-1:0]  pc_plus1;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc1;
  logic               if_id_valid;
`ifdef FETCH_PERF_EN
  logic [15:0]        fetch_count;
  logic [15:0]        stall_count;

  modport master (
    input  pc_next, stall, flush, imem_data,
    output imem_addr, pc_plus1, if_id_instr, if_id_pc1, if_id_valid,
           fetch_count, stall_count
  );

  modport slave (
    output pc_next, stall, flush, imem_data,
    input  imem_addr, pc_plus1, if_id_instr, if_id_pc1, if_id_valid,
           fetch_count, stall_count
  );
`else
  modport master (
    input  pc_next, stall, flush, imem_data,
    output imem_addr, pc_plus1, if_id_instr, if_id_pc1, if_id_valid
  );

  modport slave (
    output pc_next, stall, flush, imem_data,
    input  imem_addr, pc_plus1, if_id_instr, if_id_pc1, if_id_valid
  );
`endif

endinterface

// File: rtl/fetch_stage_pc_register.sv
// rtl/fetch_stage_pc_register.sv - program counter register with async reset and load enable
module pc_register #(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // PC loads the next address whenever enabled, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= RESET_PC;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, imem drive, IF/ID register; optional FETCH_PERF_EN counters
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = fetch_stage_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_stage_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic               pc_load;
  logic               load_slot;
  fetch_state_t       state;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc1_q;

  // A flush must redirect the PC even while the hazard unit is stalling.
  assign pc_load   = ~fif.stall | fif.flush;
  // A real instruction enters IF/ID only on an unstalled, unflushed edge.
  assign load_slot = ~fif.stall & ~fif.flush;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (fif.pc_next),
    .q     (pc)
  );

  // Increment wraps at 2^ADDR_W; carry out is deliberately dropped.
  assign pc_inc        = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign fif.imem_addr = pc;
  assign fif.pc_plus1  = pc_inc;

  // IF/ID register and RUN/BUBBLE control: flush squashes, stall holds, otherwise load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_BUBBLE;
      instr_q <= NOP_WORD[INSTR_W-1:0];
      pc1_q   <= '0;
    end else if (fif.flush) begin
      state   <= ST_BUBBLE;
      instr_q <= NOP_WORD[INSTR_W-1:0];
      pc1_q   <= '0;
    end else if (!fif.stall) begin
      state   <= ST_RUN;
      instr_q <= fif.imem_data;
      pc1_q   <= pc_inc;
    end
  end

  assign fif.if_id_instr = instr_q;
  assign fif.if_id_pc1   = pc1_q;
  assign fif.if_id_valid = (state == ST_RUN);

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counts of loaded instructions and of pure stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_slot)
        fetch_cnt_q <= sat_inc16(fetch_cnt_q);
      if (fif.stall && !fif.flush)
        stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign fif.fetch_count = fetch_cnt_q;
  assign fif.stall_count = stall_cnt_q;
`else
  logic unused_load_slot;
  assign unused_load_slot = load_slot;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage (FETCH_PERF_EN checks when defined)
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if #(.ADDR_W(11), .INSTR_W(32)) fif ();

  fetch_stage #(.ADDR_W(11), .INSTR_W(32), .RESET_PC(11'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word at address A is 0xA000_0000 | A.
  assign fif.imem_data = 32'hA000_0000 | {21'b0, fif.imem_addr};

  typedef struct {
    logic [10:0] pc;
    logic [31:0] instr;
    logic [10:0] pc1;
    logic        valid;
    logic [15:0] fcnt;
    logic [15:0] scnt;
  } exp_t;

  exp_t        sb[$];
  logic [10:0] m_pc;
  logic [31:0] m_instr;
  logic [10:0] m_pc1;
  logic        m_valid;
  logic [15:0] m_fcnt;
  logic [15:0] m_scnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 11'h000; m_instr = 32'h0; m_pc1 = 11'h000; m_valid = 1'b0;
    m_fcnt = 16'h0; m_scnt = 16'h0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".imem_addr"}, {21'b0, fif.imem_addr}, {21'b0, m_pc});
    chk({tag, ".pc_plus1"},  {21'b0, fif.pc_plus1},  {21'b0, m_pc + 11'd1});
    chk({tag, ".instr"},     fif.if_id_instr,        m_instr);
    chk({tag, ".pc1"},       {21'b0, fif.if_id_pc1}, {21'b0, m_pc1});
    chk({tag, ".valid"},     {31'b0, fif.if_id_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
    chk({tag, ".fetch_count"}, {16'b0, fif.fetch_count}, {16'b0, m_fcnt});
    chk({tag, ".stall_count"}, {16'b0, fif.stall_count}, {16'b0, m_scnt});
`endif
  endtask

  // One clock: drive inputs, predict, push, take the edge, pop and compare.
  task automatic step(input string tag, input logic st, input logic fl, input logic [10:0] nxt);
    exp_t e;
    fif.stall   = st;
    fif.flush   = fl;
    fif.pc_next = nxt;
    #1;
    chk({tag, ".pre_addr"}, {21'b0, fif.imem_addr}, {21'b0, m_pc});
    chk({tag, ".pre_pc1"},  {21'b0, fif.pc_plus1},  {21'b0, m_pc + 11'd1});
    e.pc = m_pc; e.instr = m_instr; e.pc1 = m_pc1; e.valid = m_valid;
    e.fcnt = m_fcnt; e.scnt = m_scnt;
    if (fl) begin
      e.pc = nxt; e.instr = 32'h0; e.pc1 = 11'h000; e.valid = 1'b0;
    end else if (!st) begin
      e.pc = nxt; e.instr = 32'hA000_0000 | {21'b0, m_pc}; e.pc1 = m_pc + 11'd1; e.valid = 1'b1;
      if (m_fcnt != 16'hFFFF) e.fcnt = m_fcnt + 16'd1;
    end else begin
      if (m_scnt != 16'hFFFF) e.scnt = m_scnt + 16'd1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    m_pc = e.pc; m_instr = e.instr; m_pc1 = e.pc1; m_valid = e.valid;
    m_fcnt = e.fcnt; m_scnt = e.scnt;
    chk_state(tag);
  endtask

  initial begin
    reset = 1'b1;
    fif.stall = 1'b0;
    fif.flush = 1'b0;
    fif.pc_next = 11'h000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    reset = 1'b0;

    // Sequential fetch from 0; first edge yields address 0.
    step("t1_first", 1'b0, 1'b0, m_pc + 11'd1);
    chk("t1_instr0", fif.if_id_instr, 32'hA000_0000);
    while (m_pc != 11'd5) step("t1_run", 1'b0, 1'b0, m_pc + 11'd1);

    // Stall 3 cycles at PC=5.
    repeat (3) begin
      step("t2_stall", 1'b1, 1'b0, m_pc + 11'd1);
      chk("t2_addr5", {21'b0, fif.imem_addr}, 32'd5);
      chk("t2_hold", fif.if_id_instr, 32'hA000_0004);
    end
    step("t2_release", 1'b0, 1'b0, m_pc + 11'd1);
    chk("t2_instr5", fif.if_id_instr, 32'hA000_0005);
    while (m_pc != 11'd9) step("t2_run", 1'b0, 1'b0, m_pc + 11'd1);

    // Flush to 0x040 at PC=9.
    step("t3_flush", 1'b0, 1'b1, 11'h040);
    chk("t3_bubble", {31'b0, fif.if_id_valid}, 32'd0);
    chk("t3_pc", {21'b0, fif.imem_addr}, 32'h040);
    step("t3_target", 1'b0, 1'b0, m_pc + 11'd1);
    chk("t3_instr40", fif.if_id_instr, 32'hA000_0040);

    // Flush and stall together: flush wins.
    step("t4_flush_stall", 1'b1, 1'b1, 11'h100);
    chk("t4_pc", {21'b0, fif.imem_addr}, 32'h100);
    step("t4_run", 1'b0, 1'b0, m_pc + 11'd1);

    // PC wrap at 0x7FF.
    step("t5_to_7ff", 1'b0, 1'b1, 11'h7FF);
    chk("t5_plus1_wrap", {21'b0, fif.pc_plus1}, 32'h000);
    step("t5_wrap", 1'b0, 1'b0, fif.pc_plus1);
    chk("t5_pc0", {21'b0, fif.imem_addr}, 32'h000);
    step("t5_fetch0", 1'b0, 1'b0, m_pc + 11'd1);
    chk("t5_instr0", fif.if_id_instr, 32'hA000_0000);

    // Async reset mid-stall, asserted between edges.
    step("t6_stall", 1'b1, 1'b0, m_pc + 11'd1);
    step("t6_stall", 1'b1, 1'b0, m_pc + 11'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_state("t6_async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    fif.stall = 1'b0;
    step("t6_after", 1'b0, 1'b0, m_pc + 11'd1);
    chk("t6_first_valid", {31'b0, fif.if_id_valid}, 32'd1);

`ifdef FETCH_PERF_EN
    // Long unstalled run saturates fetch_count.
    repeat (70000) step("perf", 1'b0, 1'b0, m_pc + 11'd1);
    chk("perf_sat", {16'b0, fif.fetch_count}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
